hazard_sequencer: RTL and testbench
===================================

Name: hazard_sequencer

Overview:
- Pipeline sequencing controller for the 5-stage MIPS core (IF, ID, EX, MEM, WB). It sits beside the main decoder and consumes the same ID-stage opcode, funct and register fields.
- Keeps its own shadow scoreboard of the EX, MEM and WB stages.
- Drives PC/IF-ID write enables, the IF-ID flush, bubble insertion into ID/EX, and the EX-stage forwarding selects.
- Sequences halt: drains the pipeline, then raises halted.

Parameters:
DRAIN_CYCLES, 4, cycles from halt acceptance in ID to halted=1 (halt passes EX, MEM, WB, then one retire cycle)
CNT_W, 3, width of the drain counter; must hold DRAIN_CYCLES

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
id_valid  input  1  IF/ID holds a real instruction
id_opcode  input  6  instr[31:26] in ID
id_funct  input  6  instr[5:0] in ID
id_rs  input  5  instr[25:21]
id_rt  input  5  instr[20:16]
id_rd  input  5  instr[15:11]
id_halt  input  1  ID instruction is 32'hFFFFFFFF
ex_branch_taken  input  1  beq/bne resolved taken in EX this cycle
pc_write  output  1  PC update enable
if_id_write  output  1  IF/ID register enable
if_id_flush  output  1  clear IF/ID to bubble at next edge
id_ex_bubble  output  1  ID/EX loads a bubble (all control zero) at next edge
fwd_a  output  2  EX operand A select: 00 regfile, 10 from MEM, 01 from WB
fwd_b  output  2  EX operand B select, same encoding
halted  output  1  registered; pipeline drained, core stopped

Behaviour:
- ID decode, combinational:
  - opcode 0, funct!=8: writes rd, uses rt. Uses rs unless funct is 0, 2 or 3 (shamt shifts).
  - opcode 0, funct 8 (jr): uses rs, no write.
  - 8/9/c/d/e: use rs, write rt.
  - 23 (lw): uses rs, writes rt, load=1.
  - 2b (sw) and 4/5 (beq/bne): use rs and rt, no write.
  - Any other opcode: no use, no write.
  - Destination 0 forces write=0. id_valid=0 means no use and no write.
- Scoreboard entries EX, MEM, WB each hold {valid, wr, load, dst, rs, rt, use_rs, use_rt}.
  - Every edge: WB<=MEM, MEM<=EX.
  - EX<=decoded ID entry, or an invalid entry when id_ex_bubble=1.
- Load-use stall, combinational: EX.valid & EX.load & EX.wr & id_valid, and EX.dst matches (use_rs & id_rs) or (use_rt & id_rt).
  - Response: pc_write=0, if_id_write=0, id_ex_bubble=1. Lasts exactly 1 cycle; the load then sits in MEM.
- Taken branch: ex_branch_taken=1 gives if_id_flush=1, id_ex_bubble=1, pc_write=1 (target loads) and if_id_write=1.
  - Takes priority over load-use stall and over halt acceptance in the same cycle.
- Forwarding, computed from the EX entry:
  - fwd_a=10 if MEM.valid & MEM.wr & !MEM.load & MEM.dst==EX.rs & EX.use_rs.
  - Otherwise fwd_a=01 if WB.valid & WB.wr & WB.dst==EX.rs & EX.use_rs.
  - Otherwise 00.
  - fwd_b: same rule with rt/use_rt. MEM wins over WB.
- FSM: RUN, DRAIN, DONE.
  - RUN→DRAIN: id_valid & id_halt, with no stall and no taken branch that cycle. Counter loads 1.
  - DRAIN: pc_write=0, if_id_write=0. Scoreboard keeps shifting; ID enters EX as invalid. Counter increments each cycle. At counter==DRAIN_CYCLES-1, next state is DONE.
  - DONE: halted=1, pc_write=0, if_id_write=0, all bubble/flush=0. Exit only by reset.
  - A halt squashed by a taken branch never enters DRAIN.
- Reset (rst_n=0 at an edge):
  - All entries invalid, state RUN, counter 0, halted=0.
  - While rst_n=0, pc_write=0 and if_id_write=0. Other outputs follow the cleared state: flush 0, bubble 0, fwd 00.
  - Reset mid-DRAIN or in DONE returns to RUN at the next edge.

Test Plan:
- lw $2,0($1) in EX, add $3,$2,$4 in ID → one cycle with pc_write=0, if_id_write=0, id_ex_bubble=1. Next cycle add is in EX with fwd_a=01 and no stall.
- add $5,$1,$1 then sub $6,$5,$5 back-to-back → when sub is in EX, fwd_a=10 and fwd_b=10. With one nop between them, both are 01.
- Writes to $0 (addi $0,$1,7) followed by a reader of $0 → fwd 00, no stall.
- ex_branch_taken=1 while ID holds a load-use consumer → if_id_flush=1, id_ex_bubble=1, pc_write=1. Stall suppressed.
- Halt word in ID → DRAIN. pc_write=0 from the next cycle; halted=1 exactly 4 cycles after acceptance and held. Halt in ID with a taken branch in the same cycle → stays RUN.
- rst_n=0 for one edge during DRAIN → state RUN, halted=0, fwd 00. pc_write=1 once rst_n=1.

Source files
------------

// File: rtl/hazard_sequencer_if.sv
// Bundle of ID-stage decode fields, branch resolution and the pipeline
// control outputs exchanged between the core datapath and the sequencer.
interface hazard_sequencer_if;
    logic       id_valid;
    logic [5:0] id_opcode;
    logic [5:0] id_funct;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic [4:0] id_rd;
    logic       id_halt;
    logic       ex_branch_taken;
    logic       pc_write;
    logic       if_id_write;
    logic       if_id_flush;
    logic       id_ex_bubble;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic       halted;

    // Datapath side: supplies the ID fields, receives the control.
    modport master (
        output id_valid, id_opcode, id_funct, id_rs, id_rt, id_rd, id_halt,
               ex_branch_taken,
        input  pc_write, if_id_write, if_id_flush, id_ex_bubble, fwd_a, fwd_b,
               halted
    );

    // Sequencer side.
    modport slave (
        input  id_valid, id_opcode, id_funct, id_rs, id_rt, id_rd, id_halt,
               ex_branch_taken,
        output pc_write, if_id_write, if_id_flush, id_ex_bubble, fwd_a, fwd_b,
               halted
    );
endinterface

// File: rtl/hazard_sequencer.sv
// Pipeline sequencing controller for a 5-stage MIPS core: shadow scoreboard
// of EX/MEM/WB, load-use stall, taken-branch flush, EX forwarding selects
// and halt draining.
module hazard_sequencer #(
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_W        = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    hazard_sequencer_if.slave bus
);

    typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, DONE = 2'd2} state_t;

    typedef struct packed {
        logic       valid;
        logic       wr;
        logic       load;
        logic [4:0] dst;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       use_rs;
        logic       use_rt;
    } entry_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    entry_t             ex_reg, mem_reg, wb_reg;
    entry_t             id_entry, ex_next;
    logic               halted_reg;
    logic               load_use;
    logic               pc_write_c, if_id_write_c, if_id_flush_c, id_ex_bubble_c;

    // Decode the ID instruction into its register use/write footprint
    always_comb begin
        id_entry    = '0;
        id_entry.rs = bus.id_rs;
        id_entry.rt = bus.id_rt;
        case (bus.id_opcode)
            6'h00: begin
                if (bus.id_funct == 6'h08) begin
                    id_entry.use_rs = 1'b1;
                end else begin
                    id_entry.wr     = 1'b1;
                    id_entry.dst    = bus.id_rd;
                    id_entry.use_rt = 1'b1;
                    // shamt shifts take their source from rt only
                    id_entry.use_rs = !(bus.id_funct == 6'h00 || bus.id_funct == 6'h02 ||
                                        bus.id_funct == 6'h03);
                end
            end
            6'h08, 6'h09, 6'h0c, 6'h0d, 6'h0e: begin
                id_entry.use_rs = 1'b1;
                id_entry.wr     = 1'b1;
                id_entry.dst    = bus.id_rt;
            end
            6'h23: begin
                id_entry.use_rs = 1'b1;
                id_entry.wr     = 1'b1;
                id_entry.load   = 1'b1;
                id_entry.dst    = bus.id_rt;
            end
            6'h2b, 6'h04, 6'h05: begin
                id_entry.use_rs = 1'b1;
                id_entry.use_rt = 1'b1;
            end
            default: ;
        endcase
        // $0 is hardwired, so a write to it is never a producer
        if (id_entry.dst == 5'd0) begin
            id_entry.wr = 1'b0;
        end
        if (!bus.id_valid) begin
            id_entry.use_rs = 1'b0;
            id_entry.use_rt = 1'b0;
            id_entry.wr     = 1'b0;
            id_entry.load   = 1'b0;
        end
        id_entry.valid = bus.id_valid;
    end

    assign load_use = ex_reg.valid && ex_reg.load && ex_reg.wr && bus.id_valid &&
                      ((id_entry.use_rs && ex_reg.dst == bus.id_rs) ||
                       (id_entry.use_rt && ex_reg.dst == bus.id_rt));

    // Next-state and pipeline control outputs of the run/drain/done sequencer
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        pc_write_c     = 1'b1;
        if_id_write_c  = 1'b1;
        if_id_flush_c  = 1'b0;
        id_ex_bubble_c = 1'b0;
        case (state_reg)
            RUN: begin
                if (bus.ex_branch_taken) begin
                    // redirect wins: the wrong-path ID instruction is discarded
                    if_id_flush_c  = 1'b1;
                    id_ex_bubble_c = 1'b1;
                end else if (load_use) begin
                    pc_write_c     = 1'b0;
                    if_id_write_c  = 1'b0;
                    id_ex_bubble_c = 1'b1;
                end else if (bus.id_valid && bus.id_halt) begin
                    state_next = DRAIN;
                    cnt_next   = CNT_W'(1);
                end
            end
            DRAIN: begin
                pc_write_c     = 1'b0;
                if_id_write_c  = 1'b0;
                id_ex_bubble_c = 1'b1;
                cnt_next       = cnt_reg + 1'b1;
                if (cnt_reg == CNT_W'(DRAIN_CYCLES - 1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                pc_write_c    = 1'b0;
                if_id_write_c = 1'b0;
            end
            default: begin
                state_next = RUN;
            end
        endcase
        if (!rst_n) begin
            pc_write_c     = 1'b0;
            if_id_write_c  = 1'b0;
            if_id_flush_c  = 1'b0;
            id_ex_bubble_c = 1'b0;
        end
    end

    // Only a running, non-bubbled cycle lets the ID instruction into EX
    assign ex_next = (state_reg == RUN && !id_ex_bubble_c) ? id_entry : '0;

    // Sequencer state and shadow scoreboard shift
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= RUN;
            cnt_reg    <= '0;
            ex_reg     <= '0;
            mem_reg    <= '0;
            wb_reg     <= '0;
            halted_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            ex_reg     <= ex_next;
            mem_reg    <= ex_reg;
            wb_reg     <= mem_reg;
            halted_reg <= (state_next == DONE);
        end
    end

    // Forwarding: index 0 is operand A (rs), index 1 is operand B (rt)
    logic [1:0][4:0] ex_src;
    logic [1:0]      ex_use;
    logic [1:0][1:0] fwd_sel;

    assign ex_src[0] = ex_reg.rs;
    assign ex_src[1] = ex_reg.rt;
    assign ex_use[0] = ex_reg.use_rs;
    assign ex_use[1] = ex_reg.use_rt;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            // a load in MEM has no data yet; the stall already moved it to WB
            assign fwd_sel[gi] =
                (mem_reg.valid && mem_reg.wr && !mem_reg.load &&
                 mem_reg.dst == ex_src[gi] && ex_use[gi]) ? 2'b10 :
                (wb_reg.valid && wb_reg.wr &&
                 wb_reg.dst == ex_src[gi] && ex_use[gi])  ? 2'b01 : 2'b00;
        end
    endgenerate

    logic [24:0] unused_fields;
    assign unused_fields = {mem_reg.rs, mem_reg.rt, mem_reg.use_rs, mem_reg.use_rt,
                            wb_reg.rs, wb_reg.rt, wb_reg.use_rs, wb_reg.use_rt, wb_reg.load};

    assign bus.pc_write     = pc_write_c;
    assign bus.if_id_write  = if_id_write_c;
    assign bus.if_id_flush  = if_id_flush_c;
    assign bus.id_ex_bubble = id_ex_bubble_c;
    assign bus.fwd_a        = fwd_sel[0];
    assign bus.fwd_b        = fwd_sel[1];
    assign bus.halted       = halted_reg;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Bench for hazard_sequencer: directed hazard scenarios plus random
// instruction streams checked against an instruction-level pipeline model.
module tb_hazard_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    hazard_sequencer_if bus();

    hazard_sequencer #(.DRAIN_CYCLES(4), .CNT_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP  = 32'h0000_0000;

    int n_checks = 0;
    int n_fail   = 0;

    // instruction-level model: stage 0=EX, 1=MEM, 2=WB
    logic [31:0] m_w [3];
    bit          m_v [3];
    int          halt_age = -1;   // -1 running, else cycles since halt acceptance
    bit          known    = 0;

    logic [31:0] cur_w;
    bit          cur_v, cur_br, cur_rst, exp_lu;

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'd0, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // What an instruction word reads and writes; dst 0 means "no write"
    function automatic void info(input logic [31:0] w, output bit use_rs, output bit use_rt,
                                 output logic [4:0] dst, output bit ld);
        logic [5:0] op;
        logic [5:0] fn;
        op = w[31:26];
        fn = w[5:0];
        use_rs = 0; use_rt = 0; dst = 5'd0; ld = 0;
        if (op == 6'h00 && fn == 6'h08) begin
            use_rs = 1;
        end else if (op == 6'h00) begin
            use_rt = 1;
            dst    = w[15:11];
            use_rs = !(fn inside {6'h00, 6'h02, 6'h03});
        end else if (op inside {6'h08, 6'h09, 6'h0c, 6'h0d, 6'h0e}) begin
            use_rs = 1;
            dst    = w[20:16];
        end else if (op == 6'h23) begin
            use_rs = 1;
            dst    = w[20:16];
            ld     = 1;
        end else if (op inside {6'h2b, 6'h04, 6'h05}) begin
            use_rs = 1;
            use_rt = 1;
        end
    endfunction

    // Nearest older producer of the EX operand; an un-loaded value in MEM can't forward
    function automatic logic [1:0] exp_fwd(input bit rt_side);
        bit urs, urt, ld, used;
        logic [4:0] dst, src;
        info(m_w[0], urs, urt, dst, ld);
        used = rt_side ? urt : urs;
        src  = rt_side ? m_w[0][20:16] : m_w[0][25:21];
        if (!m_v[0] || !used) return 2'b00;
        info(m_w[1], urs, urt, dst, ld);
        if (m_v[1] && dst != 5'd0 && !ld && dst == src) return 2'b10;
        info(m_w[2], urs, urt, dst, ld);
        if (m_v[2] && dst != 5'd0 && dst == src) return 2'b01;
        return 2'b00;
    endfunction

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one ID cycle at the falling edge and check outputs against the model
    task automatic drive(input logic [31:0] w, input bit v, input bit br, input bit rn);
        bit urs, urt, ld, eurs, eurt, eld, run;
        logic [4:0] dd, edst;
        @(negedge clk);
        bus.id_valid        = v;
        bus.id_opcode       = w[31:26];
        bus.id_funct        = w[5:0];
        bus.id_rs           = w[25:21];
        bus.id_rt           = w[20:16];
        bus.id_rd           = w[15:11];
        bus.id_halt         = (w == HALT);
        bus.ex_branch_taken = br;
        rst_n               = rn;
        cur_w = w; cur_v = v; cur_br = br; cur_rst = rn;
        #1;
        run = (halt_age < 0);
        info(w, urs, urt, dd, ld);
        info(m_w[0], eurs, eurt, edst, eld);
        exp_lu = known && run && m_v[0] && eld && edst != 5'd0 && v &&
                 ((urs && edst == w[25:21]) || (urt && edst == w[20:16]));
        if (!rn) begin
            chk("rst_pc_write", bus.pc_write, 0);
            chk("rst_if_id_write", bus.if_id_write, 0);
            chk("rst_flush", bus.if_id_flush, 0);
            chk("rst_bubble", bus.id_ex_bubble, 0);
        end else if (run) begin
            chk("pc_write", bus.pc_write, br || !exp_lu);
            chk("if_id_write", bus.if_id_write, br || !exp_lu);
            chk("if_id_flush", bus.if_id_flush, br);
            chk("id_ex_bubble", bus.id_ex_bubble, br || exp_lu);
        end else begin
            chk("drain_pc_write", bus.pc_write, 0);
            chk("drain_if_id_write", bus.if_id_write, 0);
            if (halt_age >= 4) begin
                chk("done_flush", bus.if_id_flush, 0);
                chk("done_bubble", bus.id_ex_bubble, 0);
            end
        end
        if (known) begin
            chk("fwd_a", bus.fwd_a, exp_fwd(0));
            chk("fwd_b", bus.fwd_b, exp_fwd(1));
            chk("halted", bus.halted, halt_age >= 4);
        end
    endtask

    // Advance the model across the rising edge
    task automatic tick();
        @(posedge clk);
        if (!cur_rst) begin
            for (int i = 0; i < 3; i++) m_v[i] = 0;
            halt_age = -1;
            known    = 1;
        end else begin
            m_w[2] = m_w[1]; m_v[2] = m_v[1];
            m_w[1] = m_w[0]; m_v[1] = m_v[0];
            m_w[0] = cur_w;
            if (halt_age < 0) begin
                m_v[0] = cur_v && !cur_br && !exp_lu;
                if (cur_v && cur_w == HALT && !cur_br && !exp_lu) halt_age = 1;
            end else begin
                m_v[0] = 0;
                if (halt_age < 100) halt_age++;
            end
        end
    endtask

    task automatic cyc(input logic [31:0] w, input bit v, input bit br, input bit rn);
        drive(w, v, br, rn);
        tick();
    endtask

    function automatic logic [31:0] rnd_instr();
        logic [4:0] a, b, c;
        logic [5:0] fn, op;
        int k;
        a = 5'($urandom_range(0, 3));
        b = 5'($urandom_range(0, 3));
        c = 5'($urandom_range(0, 3));
        k = $urandom_range(0, 6);
        case (k)
            0: begin
                case ($urandom_range(0, 4))
                    0: fn = 6'h20; 1: fn = 6'h22; 2: fn = 6'h00; 3: fn = 6'h03; default: fn = 6'h2a;
                endcase
                return rtype(a, b, c, fn);
            end
            1: return itype(6'h23, a, b, 16'($urandom));
            2: return itype(6'h2b, a, b, 16'h4);
            3: begin
                case ($urandom_range(0, 4))
                    0: op = 6'h08; 1: op = 6'h09; 2: op = 6'h0c; 3: op = 6'h0d; default: op = 6'h0e;
                endcase
                return itype(op, a, b, 16'h7);
            end
            4: return itype($urandom_range(0, 1) ? 6'h04 : 6'h05, a, b, 16'h10);
            5: return rtype(a, 5'd0, 5'd0, 6'h08);
            default: return itype(6'h02, a, b, 16'h55);
        endcase
    endfunction

    initial begin
        for (int i = 0; i < 3; i++) begin m_v[i] = 0; m_w[i] = '0; end
        cur_w = NOP; cur_v = 0; cur_br = 0; cur_rst = 0; exp_lu = 0;

        // reset
        cyc(NOP, 0, 0, 0);
        cyc(NOP, 0, 0, 0);

        // lw $2,0($1) then add $3,$2,$4: one stall cycle, then forward from WB
        cyc(itype(6'h23, 5'd1, 5'd2, 16'd0), 1, 0, 1);
        drive(rtype(5'd2, 5'd4, 5'd3, 6'h20), 1, 0, 1);
        chk("lu_pc_write", bus.pc_write, 0);
        chk("lu_if_id_write", bus.if_id_write, 0);
        chk("lu_bubble", bus.id_ex_bubble, 1);
        tick();
        drive(rtype(5'd2, 5'd4, 5'd3, 6'h20), 1, 0, 1);
        chk("lu_released_pc", bus.pc_write, 1);
        tick();
        drive(NOP, 1, 0, 1);
        chk("lu_fwd_a_wb", bus.fwd_a, 2'b01);
        chk("lu_no_stall", bus.id_ex_bubble, 0);
        tick();

        // back-to-back ALU dependency forwards from MEM
        cyc(rtype(5'd1, 5'd1, 5'd5, 6'h20), 1, 0, 1);
        cyc(rtype(5'd5, 5'd5, 5'd6, 6'h22), 1, 0, 1);
        drive(NOP, 1, 0, 1);
        chk("b2b_fwd_a", bus.fwd_a, 2'b10);
        chk("b2b_fwd_b", bus.fwd_b, 2'b10);
        tick();
        // one nop between: forwards from WB
        cyc(rtype(5'd1, 5'd1, 5'd5, 6'h20), 1, 0, 1);
        cyc(NOP, 1, 0, 1);
        cyc(rtype(5'd5, 5'd5, 5'd6, 6'h22), 1, 0, 1);
        drive(NOP, 1, 0, 1);
        chk("gap_fwd_a", bus.fwd_a, 2'b01);
        chk("gap_fwd_b", bus.fwd_b, 2'b01);
        tick();

        // writes to $0 never forward or stall
        cyc(itype(6'h08, 5'd1, 5'd0, 16'd7), 1, 0, 1);
        cyc(rtype(5'd0, 5'd0, 5'd5, 6'h20), 1, 0, 1);
        drive(NOP, 1, 0, 1);
        chk("zero_fwd_a", bus.fwd_a, 2'b00);
        chk("zero_fwd_b", bus.fwd_b, 2'b00);
        tick();
        cyc(itype(6'h23, 5'd1, 5'd0, 16'd0), 1, 0, 1);
        drive(rtype(5'd0, 5'd0, 5'd7, 6'h20), 1, 0, 1);
        chk("zero_load_no_stall", bus.pc_write, 1);
        tick();

        // taken branch overrides a load-use stall
        cyc(itype(6'h23, 5'd1, 5'd2, 16'd0), 1, 0, 1);
        drive(rtype(5'd2, 5'd4, 5'd3, 6'h20), 1, 1, 1);
        chk("br_flush", bus.if_id_flush, 1);
        chk("br_bubble", bus.id_ex_bubble, 1);
        chk("br_pc_write", bus.pc_write, 1);
        chk("br_if_id_write", bus.if_id_write, 1);
        tick();

        // halt squashed by a taken branch stays in RUN
        cyc(HALT, 1, 1, 1);
        drive(NOP, 1, 0, 1);
        chk("squash_pc_write", bus.pc_write, 1);
        tick();

        // halt drains, halted exactly four cycles after acceptance
        drive(HALT, 1, 0, 1);
        chk("halt_accept_pc", bus.pc_write, 1);
        tick();
        for (int i = 1; i <= 6; i++) begin
            drive(HALT, 1, 0, 1);
            chk("halt_pc_write", bus.pc_write, 0);
            chk("halt_timing", bus.halted, (i >= 4) ? 1 : 0);
            tick();
        end

        // reset out of DONE
        cyc(NOP, 0, 0, 0);
        drive(NOP, 1, 0, 1);
        chk("done_rst_pc", bus.pc_write, 1);
        chk("done_rst_halted", bus.halted, 0);
        tick();

        // reset mid-drain
        cyc(HALT, 1, 0, 1);
        cyc(HALT, 1, 0, 1);
        cyc(HALT, 1, 0, 0);
        drive(NOP, 1, 0, 1);
        chk("drain_rst_pc", bus.pc_write, 1);
        chk("drain_rst_halted", bus.halted, 0);
        chk("drain_rst_fwd_a", bus.fwd_a, 2'b00);
        chk("drain_rst_fwd_b", bus.fwd_b, 2'b00);
        tick();

        // random instruction stream against the model
        for (int n = 0; n < 400; n++) begin
            cyc(rnd_instr(), $urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
